// File: rtl/mips_debug_loader.sv
// Host-side loader/debug controller for the mips core: takes command and data bytes from the UART,
// writes program words into instruction memory, drives core stall/reset, and returns the PC as bytes.
module mips_debug_loader #(
  parameter int SIZE   = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  input  logic [SIZE-1:0]   i_pc,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [SIZE-1:0]   o_imem_data,
  output logic              o_stall,
  output logic              o_cpu_rst
);

  localparam int NB  = SIZE / 8;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BCW-1:0] LAST_B = BCW'(NB - 1);

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_HALT = 8'h48;
  localparam logic [7:0] CMD_PC   = 8'h50;

  // state     | meaning
  // IDLE      | decode one command byte per accept
  // LOAD_CNT  | next byte is the word count (0 means 256)
  // LOAD_DATA | assemble little-endian words, one imem write per word
  // SEND      | stream captured PC to host, LSB first
  typedef enum logic [1:0] {IDLE, LOAD_CNT, LOAD_DATA, SEND} state_t;

  state_t            state_q, state_d;
  logic              run_q, run_d;
  logic              stall_q, stall_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [SIZE-1:0]   imem_data_q, imem_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [8:0]        rem_q, rem_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [BCW-1:0]    bcnt_q, bcnt_d;
  logic [BCW-1:0]    scnt_q, scnt_d;
  logic [SIZE-9:0]   asm_q, asm_d;
  logic [SIZE-1:0]   pc_q, pc_d;

  logic              rx_fire;
  logic              tx_fire;
  logic [SIZE-1:0]   full_word;

  assign o_rx_ready = (state_q != SEND);
  assign rx_fire    = i_rx_valid && (state_q != SEND);
  assign tx_fire    = tx_valid_q && i_tx_ready;
  // The incoming byte lands on top; earlier bytes sit lower, giving little-endian order.
  assign full_word  = {i_rx_data, asm_q};

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    stall_d     = ~run_q;
    cpu_rst_d   = cpu_rst_q;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_data_d = imem_data_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    rem_d       = rem_q;
    widx_d      = widx_q;
    bcnt_d      = bcnt_q;
    scnt_d      = scnt_q;
    asm_d       = asm_q;
    pc_d        = pc_q;

    unique case (state_q)
      IDLE: begin
        cpu_rst_d = 1'b0;
        if (rx_fire) begin
          case (i_rx_data)
            CMD_LOAD: begin
              run_d     = 1'b0;
              stall_d   = 1'b1;
              cpu_rst_d = 1'b1;
              state_d   = LOAD_CNT;
            end
            CMD_RUN: begin
              run_d   = 1'b1;
              stall_d = 1'b0;
            end
            CMD_STEP: begin
              if (!run_q) stall_d = 1'b0;
            end
            CMD_HALT: begin
              run_d   = 1'b0;
              stall_d = 1'b1;
            end
            CMD_PC: begin
              pc_d       = i_pc;
              tx_data_d  = i_pc[7:0];
              tx_valid_d = 1'b1;
              scnt_d     = '0;
              state_d    = SEND;
            end
            default: ;
          endcase
        end
      end

      LOAD_CNT: begin
        if (rx_fire) begin
          rem_d   = (i_rx_data == 8'd0) ? 9'd256 : {1'b0, i_rx_data};
          widx_d  = '0;
          bcnt_d  = '0;
          state_d = LOAD_DATA;
        end
      end

      LOAD_DATA: begin
        if (rx_fire) begin
          asm_d = full_word[SIZE-1:8];
          if (bcnt_q == LAST_B) begin
            bcnt_d      = '0;
            imem_we_d   = 1'b1;
            imem_addr_d = widx_q;
            imem_data_d = full_word;
            widx_d      = widx_q + ADDR_W'(1);
            rem_d       = rem_q - 9'd1;
            // Core reset is released by IDLE one cycle after the final write.
            if (rem_q == 9'd1) state_d = IDLE;
          end else begin
            bcnt_d = bcnt_q + BCW'(1);
          end
        end
      end

      SEND: begin
        if (tx_fire) begin
          if (scnt_q == LAST_B) begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end else begin
            scnt_d    = scnt_q + BCW'(1);
            pc_d      = pc_q >> 8;
            tx_data_d = pc_q[15:8];
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      stall_q     <= 1'b1;
      cpu_rst_q   <= 1'b1;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      rem_q       <= '0;
      widx_q      <= '0;
      bcnt_q      <= '0;
      scnt_q      <= '0;
      asm_q       <= '0;
      pc_q        <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      stall_q     <= stall_d;
      cpu_rst_q   <= cpu_rst_d;
      imem_we_q   <= imem_we_d;
      imem_addr_q <= imem_addr_d;
      imem_data_q <= imem_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      rem_q       <= rem_d;
      widx_q      <= widx_d;
      bcnt_q      <= bcnt_d;
      scnt_q      <= scnt_d;
      asm_q       <= asm_d;
      pc_q        <= pc_d;
    end
  end

  assign o_stall     = stall_q;
  assign o_cpu_rst   = cpu_rst_q;
  assign o_imem_we   = imem_we_q;
  assign o_imem_addr = imem_addr_q;
  assign o_imem_data = imem_data_q;
  assign o_tx_valid  = tx_valid_q;
  assign o_tx_data   = tx_data_q;

endmodule
